async_transmitter: RTL and testbench

- RS-232-style serial transmitter: 8N1 by default, with optional parity and 2 stop bits. It is the TX side of the host serial link.
- Accepts a byte per valid/ready handshake, buffers one extra byte in a holding register, and shifts frames LSB-first on TxD.
- A fractional-accumulator baud generator sets timing. The line idles high.

---
 rtl/async_transmitter.sv | 160 ++++++++++++++++
 tb/tb_async_transmitter.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/async_transmitter.sv
// RS-232 style serial transmitter with a one-byte holding register.
// A fractional-accumulator baud generator paces START/DATA/PARITY/STOP bits.
module async_transmitter #(
  parameter int unsigned ClkFrequency          = 32000000,
  parameter int unsigned Baud                  = 2000000,
  parameter int unsigned BaudGeneratorAccWidth = 16,
  parameter int unsigned Parity                = 0,
  parameter int unsigned StopBits              = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       TxD_start,
  input  logic [7:0] TxD_data,
  output logic       TxD,
  output logic       TxD_ready,
  output logic       TxD_busy,
  output logic       TxD_done
);

  localparam int unsigned AccW    = BaudGeneratorAccWidth;
  localparam logic [63:0] IncWide =
    ((64'(Baud) << AccW) + 64'(ClkFrequency / 2)) / 64'(ClkFrequency);
  localparam logic [AccW:0] Inc      = IncWide[AccW:0];
  localparam logic          ParityOdd = (Parity == 2);
  localparam logic [2:0]    LastStop  = 3'(StopBits - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t          state, stateNext;
  logic [7:0]      shiftReg, shiftNext;
  logic [2:0]      bitIdx, bitIdxNext;
  logic [7:0]      holdData, holdDataNext;
  logic            holdValid, holdValidNext;
  logic            parityBit, parityNext;
  logic [AccW-1:0] acc, accNext;
  logic [AccW:0]   accSum;
  logic            tick, accept, directLoad, doneNext, txdNext;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= stateNext;
  end

  // Next-state, baud accumulator, holding register and line value.
  always_comb begin
    stateNext     = state;
    shiftNext     = shiftReg;
    bitIdxNext    = bitIdx;
    holdDataNext  = holdData;
    holdValidNext = holdValid;
    parityNext    = parityBit;
    accNext       = acc;
    doneNext      = 1'b0;
    directLoad    = 1'b0;
    txdNext       = 1'b1;
    accept        = TxD_start & TxD_ready;
    accSum        = {1'b0, acc} + Inc;
    tick          = (state != IDLE) & accSum[AccW];

    if (state != IDLE) accNext = accSum[AccW-1:0];

    case (state)
      IDLE: begin
        if (accept) begin
          stateNext  = START;
          shiftNext  = TxD_data;
          parityNext = (^TxD_data) ^ ParityOdd;
          accNext    = '0;
          directLoad = 1'b1;
        end
      end
      START: begin
        if (tick) begin
          stateNext  = DATA;
          bitIdxNext = '0;
        end
      end
      DATA: begin
        if (tick) begin
          if (bitIdx == 3'd7) begin
            stateNext  = (Parity != 0) ? PARITY : STOP;
            bitIdxNext = '0;
          end else begin
            shiftNext  = {1'b0, shiftReg[7:1]};
            bitIdxNext = bitIdx + 3'd1;
          end
        end
      end
      PARITY: begin
        if (tick) begin
          stateNext  = STOP;
          bitIdxNext = '0;
        end
      end
      STOP: begin
        if (tick) begin
          if (bitIdx == LastStop) begin
            // Chain the next frame with no idle gap when a byte is available.
            if (holdValid) begin
              stateNext     = START;
              shiftNext     = holdData;
              parityNext    = (^holdData) ^ ParityOdd;
              holdValidNext = 1'b0;
            end else if (accept) begin
              stateNext  = START;
              shiftNext  = TxD_data;
              parityNext = (^TxD_data) ^ ParityOdd;
              directLoad = 1'b1;
            end else begin
              stateNext = IDLE;
              doneNext  = 1'b1;
            end
          end else begin
            bitIdxNext = bitIdx + 3'd1;
          end
        end
      end
      default: stateNext = IDLE;
    endcase

    if (accept && !directLoad) begin
      holdDataNext  = TxD_data;
      holdValidNext = 1'b1;
    end

    case (stateNext)
      START:   txdNext = 1'b0;
      DATA:    txdNext = shiftNext[0];
      PARITY:  txdNext = parityNext;
      default: txdNext = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shiftReg  <= '0;
      bitIdx    <= '0;
      holdData  <= '0;
      holdValid <= 1'b0;
      parityBit <= 1'b0;
      acc       <= '0;
      TxD       <= 1'b1;
      TxD_ready <= 1'b1;
      TxD_busy  <= 1'b0;
      TxD_done  <= 1'b0;
    end else begin
      shiftReg  <= shiftNext;
      bitIdx    <= bitIdxNext;
      holdData  <= holdDataNext;
      holdValid <= holdValidNext;
      parityBit <= parityNext;
      acc       <= accNext;
      TxD       <= txdNext;
      TxD_ready <= ~holdValidNext;
      TxD_busy  <= (stateNext != IDLE) | holdValidNext;
      TxD_done  <= doneNext;
    end
  end

endmodule

// File: tb/tb_async_transmitter.sv
// Bench for async_transmitter: default 8N1 instance plus an odd-parity,
// two-stop-bit instance, both checked against a frame-timing model.
module tb_async_transmitter;

  logic       clk;
  logic       rst;
  logic       startA, startB;
  logic [7:0] txData;
  logic       txdA, readyA, busyA, doneA;
  logic       txdB, readyB, busyB, doneB;
  logic       mode;
  logic       obsTxD, obsReady, obsBusy, obsDone;

  int checks;
  int errors;

  async_transmitter dutA (
    .clk(clk), .rst(rst), .TxD_start(startA), .TxD_data(txData),
    .TxD(txdA), .TxD_ready(readyA), .TxD_busy(busyA), .TxD_done(doneA)
  );

  async_transmitter #(.Parity(2), .StopBits(2)) dutB (
    .clk(clk), .rst(rst), .TxD_start(startB), .TxD_data(txData),
    .TxD(txdB), .TxD_ready(readyB), .TxD_busy(busyB), .TxD_done(doneB)
  );

  assign obsTxD   = mode ? txdB   : txdA;
  assign obsReady = mode ? readyB : readyA;
  assign obsBusy  = mode ? busyB  : busyA;
  assign obsDone  = mode ? doneB  : doneA;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: each accepted byte owns a frame with a start time; the
  // line, ready, busy and done follow from frame start times alone.
  int         t;
  int         fStart[$];
  logic [7:0] fData[$];
  int         frameClks;
  int         parMode;
  bit         mReady;
  bit         expTxD, expReady, expBusy, expDone;

  function automatic bit frame_bit(input logic [7:0] d, input int idx);
    if (idx == 0) return 1'b0;
    if (idx <= 8) return d[idx-1];
    if (parMode != 0 && idx == 9) return (($countones(d) % 2) == 1) ^ (parMode == 2);
    return 1'b1;
  endfunction

  task automatic clk_step(input bit offer, input logic [7:0] d);
    int lastEnd;
    startA = offer && !mode;
    startB = offer && mode;
    txData = d;
    @(posedge clk);
    t++;
    if (offer && mReady) begin
      if (fStart.size() == 0) fStart.push_back(t);
      else if (t >= fStart[$] + frameClks) fStart.push_back(t);
      else fStart.push_back(fStart[$] + frameClks);
      fData.push_back(d);
    end
    expTxD = 1'b1; expReady = 1'b1; expBusy = 1'b0; expDone = 1'b0;
    if (fStart.size() > 0) begin
      lastEnd  = fStart[$] + frameClks;
      expBusy  = lastEnd > t;
      expDone  = (t == lastEnd);
      expReady = !(fStart[$] > t);
      for (int i = fStart.size() - 1; i >= 0; i--) begin
        if (fStart[i] <= t) begin
          if (t < fStart[i] + frameClks) expTxD = frame_bit(fData[i], (t - fStart[i]) / 16);
          break;
        end
      end
    end
    mReady = expReady;
    #1;
  endtask

  task automatic release_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    fStart.delete();
    fData.delete();
    t = 0;
    mReady = 1'b1;
  endtask

  task automatic do_reset(input logic m);
    startA = 1'b0;
    startB = 1'b0;
    rst = 1'b1;
    mode = m;
    frameClks = m ? 12 * 16 : 10 * 16;
    parMode = m ? 2 : 0;
    release_reset();
  endtask

  task automatic test_reset();
    do_reset(1'b0);
    for (int j = 0; j < 40; j++) clk_step(j == 0, 8'h5A);
    #3 rst = 1'b1;
    #1;
    checks += 4;
    if (txdA !== 1'b1)   begin errors++; $display("FAIL reset_txd got %b exp 1", txdA); end
    if (readyA !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", readyA); end
    if (busyA !== 1'b0)  begin errors++; $display("FAIL reset_busy got %b exp 0", busyA); end
    if (doneA !== 1'b0)  begin errors++; $display("FAIL reset_done got %b exp 0", doneA); end
    release_reset();
    for (int j = 0; j < 1000; j++) begin
      clk_step(1'b0, 8'($urandom));
      checks += 4;
      if (obsTxD !== 1'b1)   begin errors++; $display("FAIL idle_txd t=%0d got %b exp 1", t, obsTxD); end
      if (obsReady !== 1'b1) begin errors++; $display("FAIL idle_ready t=%0d got %b exp 1", t, obsReady); end
      if (obsBusy !== 1'b0)  begin errors++; $display("FAIL idle_busy t=%0d got %b exp 0", t, obsBusy); end
      if (obsDone !== 1'b0)  begin errors++; $display("FAIL idle_done t=%0d got %b exp 0", t, obsDone); end
    end
  endtask

  task automatic test_single();
    do_reset(1'b0);
    for (int j = 0; j < 180; j++) begin
      clk_step(j == 0, 8'h55);
      checks += 4;
      if (obsTxD !== expTxD)     begin errors++; $display("FAIL single_txd j=%0d got %b exp %b", j, obsTxD, expTxD); end
      if (obsReady !== expReady) begin errors++; $display("FAIL single_ready j=%0d got %b exp %b", j, obsReady, expReady); end
      if (obsBusy !== expBusy)   begin errors++; $display("FAIL single_busy j=%0d got %b exp %b", j, obsBusy, expBusy); end
      if (obsDone !== (j == 160)) begin errors++; $display("FAIL single_done j=%0d got %b exp %b", j, obsDone, (j == 160)); end
    end
  endtask

  task automatic test_back_to_back();
    do_reset(1'b0);
    for (int j = 0; j < 340; j++) begin
      clk_step(j == 0 || j == 5, (j == 0) ? 8'hA3 : 8'h0F);
      checks += 4;
      if (obsTxD !== expTxD)     begin errors++; $display("FAIL b2b_txd j=%0d got %b exp %b", j, obsTxD, expTxD); end
      if (obsReady !== expReady) begin errors++; $display("FAIL b2b_ready j=%0d got %b exp %b", j, obsReady, expReady); end
      if (obsBusy !== expBusy)   begin errors++; $display("FAIL b2b_busy j=%0d got %b exp %b", j, obsBusy, expBusy); end
      if (obsDone !== (j == 320)) begin errors++; $display("FAIL b2b_done j=%0d got %b exp %b", j, obsDone, (j == 320)); end
      if (j == 6) begin
        checks++;
        if (obsReady !== 1'b0) begin errors++; $display("FAIL b2b_ready_k6 got %b exp 0", obsReady); end
      end
      if (j == 160) begin
        checks++;
        if (obsTxD !== 1'b0) begin errors++; $display("FAIL b2b_second_start got %b exp 0", obsTxD); end
      end
    end
  endtask

  task automatic test_overflow();
    logic [7:0] b [3];
    do_reset(1'b0);
    for (int i = 0; i < 3; i++) b[i] = 8'($urandom);
    for (int j = 0; j < 360; j++) begin
      clk_step(j == 0 || j == 3 || j == 6, (j == 0) ? b[0] : (j == 3) ? b[1] : b[2]);
      checks += 4;
      if (obsTxD !== expTxD)     begin errors++; $display("FAIL ovf_txd j=%0d got %b exp %b", j, obsTxD, expTxD); end
      if (obsReady !== expReady) begin errors++; $display("FAIL ovf_ready j=%0d got %b exp %b", j, obsReady, expReady); end
      if (obsBusy !== expBusy)   begin errors++; $display("FAIL ovf_busy j=%0d got %b exp %b", j, obsBusy, expBusy); end
      if (obsDone !== expDone)   begin errors++; $display("FAIL ovf_done j=%0d got %b exp %b", j, obsDone, expDone); end
      if (j == 159 || j == 160) begin
        checks++;
        if (obsReady !== (j == 160)) begin errors++; $display("FAIL ovf_ready_edge j=%0d got %b exp %b", j, obsReady, (j == 160)); end
      end
      if (j >= 320) begin
        checks++;
        if (obsTxD !== 1'b1) begin errors++; $display("FAIL ovf_extra_frame j=%0d got %b exp 1", j, obsTxD); end
      end
    end
  endtask

  task automatic test_random(input logic m, input int cycles);
    bit offer;
    do_reset(m);
    for (int j = 0; j < cycles; j++) begin
      offer = ($urandom_range(0, 7) == 0);
      clk_step(offer, 8'($urandom));
      checks += 4;
      if (obsTxD !== expTxD)     begin errors++; $display("FAIL rand%0d_txd t=%0d got %b exp %b", m, t, obsTxD, expTxD); end
      if (obsReady !== expReady) begin errors++; $display("FAIL rand%0d_ready t=%0d got %b exp %b", m, t, obsReady, expReady); end
      if (obsBusy !== expBusy)   begin errors++; $display("FAIL rand%0d_busy t=%0d got %b exp %b", m, t, obsBusy, expBusy); end
      if (obsDone !== expDone)   begin errors++; $display("FAIL rand%0d_done t=%0d got %b exp %b", m, t, obsDone, expDone); end
    end
  endtask

  task automatic test_parity();
    do_reset(1'b1);
    for (int j = 0; j < 210; j++) begin
      clk_step(j == 0, 8'h07);
      checks += 4;
      if (obsTxD !== expTxD)     begin errors++; $display("FAIL par_txd j=%0d got %b exp %b", j, obsTxD, expTxD); end
      if (obsReady !== expReady) begin errors++; $display("FAIL par_ready j=%0d got %b exp %b", j, obsReady, expReady); end
      if (obsBusy !== (j < 192)) begin errors++; $display("FAIL par_busy j=%0d got %b exp %b", j, obsBusy, (j < 192)); end
      if (obsDone !== (j == 192)) begin errors++; $display("FAIL par_done j=%0d got %b exp %b", j, obsDone, (j == 192)); end
      if (j == 9 * 16 + 8) begin
        checks++;
        if (obsTxD !== 1'b0) begin errors++; $display("FAIL par_bit got %b exp 0", obsTxD); end
      end
    end
  endtask

  task automatic test_async_reset();
    do_reset(1'b0);
    for (int j = 0; j <= 16 * 5 + 4; j++) begin
      clk_step(j == 0 || j == 5, (j == 0) ? 8'hC6 : 8'h3B);
      checks += 2;
      if (obsTxD !== expTxD)     begin errors++; $display("FAIL ar_txd j=%0d got %b exp %b", j, obsTxD, expTxD); end
      if (obsReady !== expReady) begin errors++; $display("FAIL ar_ready j=%0d got %b exp %b", j, obsReady, expReady); end
    end
    #3 rst = 1'b1;
    #1;
    checks += 3;
    if (txdA !== 1'b1)   begin errors++; $display("FAIL ar_txd_now got %b exp 1", txdA); end
    if (readyA !== 1'b1) begin errors++; $display("FAIL ar_ready_now got %b exp 1", readyA); end
    if (busyA !== 1'b0)  begin errors++; $display("FAIL ar_busy_now got %b exp 0", busyA); end
    release_reset();
    for (int j = 0; j < 400; j++) begin
      clk_step(1'b0, 8'h00);
      checks += 3;
      if (obsTxD !== 1'b1)  begin errors++; $display("FAIL ar_residual_txd j=%0d got %b exp 1", j, obsTxD); end
      if (obsBusy !== 1'b0) begin errors++; $display("FAIL ar_residual_busy j=%0d got %b exp 0", j, obsBusy); end
      if (obsDone !== 1'b0) begin errors++; $display("FAIL ar_residual_done j=%0d got %b exp 0", j, obsDone); end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    startA = 1'b0;
    startB = 1'b0;
    txData = 8'h00;
    mode = 1'b0;
    frameClks = 160;
    parMode = 0;
    t = 0;
    mReady = 1'b1;
    test_reset();
    test_single();
    test_back_to_back();
    test_overflow();
    test_random(1'b0, 2000);
    test_parity();
    test_random(1'b1, 2000);
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
